// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM states and flag bit indices for seq_alu
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // MUL always iterates; DIV iterates unless the divisor is zero (resolved in one cycle)
    function automatic logic uses_iter(input logic [3:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu; flags present with SEQ_ALU_FLAGS_EN
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             err;
    logic             busy;
`ifdef SEQ_ALU_FLAGS_EN
    logic [3:0]       flags;
`endif

    modport master (
        output in_valid, a, b, op, out_ready,
`ifdef SEQ_ALU_FLAGS_EN
        input  flags,
`endif
        input  in_ready, out_valid, result, remainder, err, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
`ifdef SEQ_ALU_FLAGS_EN
        output flags,
`endif
        output in_ready, out_valid, result, remainder, err, busy
    );

endinterface

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - shared WIDTH-step shift-add multiplier / restoring divider
module seq_alu_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_or_quot_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W:0] LAST_STEP = (SH_W + 1)'(WIDTH - 1);

    // x: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y: multiplier (MUL) or divisor (DIV)
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [SH_W:0]    cnt_q;
    logic             run_q, div_q;
    logic [WIDTH:0]   shifted, trial;
    logic             last;

    // one iteration step of whichever operation is running
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        shifted = {acc_q, x_q[WIDTH-1]};
        trial   = shifted - {1'b0, y_q};
        if (div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end
    end

    assign last           = run_q && (cnt_q == LAST_STEP);
    assign done_o         = last;
    assign prod_or_quot_o = div_q ? x_d : acc_d;
    assign rem_o          = div_q ? acc_d : '0;

    // load operands on start, then step once per clock until WIDTH steps are done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else if (start_i) begin
            x_q   <= a_i;
            y_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
            div_q <= is_div_i;
        end else if (run_q) begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU top: FSM and 1-cycle datapath; NZCV flags with SEQ_ALU_FLAGS_EN
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic   clk,
    input  logic   reset,
    seq_alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] result_q, remainder_q;
    logic             err_q;

    logic             in_ready;
    logic             accept;
    logic             b_zero;
    logic             iter_start;
    logic [WIDTH-1:0] res1_d, rem1_d;
    logic             err1_d;

    logic             it_done;
    logic [WIDTH-1:0] it_prod, it_rem;

    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready;
    assign b_zero     = (bus.b == '0);
    assign iter_start = accept && uses_iter(bus.op, b_zero);

    // single-cycle results, including the DIV-by-zero and illegal-opcode error cases
    always_comb begin
        res1_d = '0;
        rem1_d = '0;
        err1_d = 1'b0;
        case (bus.op)
            OP_ADD: res1_d = bus.a + bus.b;
            OP_SUB: res1_d = bus.a - bus.b;
            OP_MUL: res1_d = '0;
            OP_DIV: begin
                if (b_zero) begin
                    res1_d = '1;
                    rem1_d = bus.a;
                    err1_d = 1'b1;
                end
            end
            OP_AND: res1_d = bus.a & bus.b;
            OP_OR:  res1_d = bus.a | bus.b;
            OP_XOR: res1_d = bus.a ^ bus.b;
            OP_NOT: res1_d = ~bus.a;
            OP_SHL: res1_d = bus.a << bus.b[SH_W-1:0];
            OP_SHR: res1_d = bus.a >> bus.b[SH_W-1:0];
            default: err1_d = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_FLAGS_EN
    logic [3:0] flags_q, flags1_d, flagsi_d;

    // NZCV for both completion paths; carry/overflow only meaningful for ADD/SUB
    always_comb begin
        flags1_d         = '0;
        flags1_d[FLAG_N] = res1_d[WIDTH-1];
        flags1_d[FLAG_Z] = (res1_d == '0);
        case (bus.op)
            OP_ADD: begin
                flags1_d[FLAG_C] = (res1_d < bus.a);
                flags1_d[FLAG_V] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                   (res1_d[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                flags1_d[FLAG_C] = (bus.a < bus.b);
                flags1_d[FLAG_V] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                   (res1_d[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: ;
        endcase
        flagsi_d         = '0;
        flagsi_d[FLAG_N] = it_prod[WIDTH-1];
        flagsi_d[FLAG_Z] = (it_prod == '0);
    end

    assign bus.flags = flags_q;
`endif

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk            (clk),
        .reset          (reset),
        .start_i        (iter_start),
        .is_div_i       (bus.op == OP_DIV),
        .a_i            (bus.a),
        .b_i            (bus.b),
        .done_o         (it_done),
        .prod_or_quot_o (it_prod),
        .rem_o          (it_rem)
    );

    // handshake FSM; outputs only change on accept or iterative completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            remainder_q <= '0;
            err_q       <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            flags_q     <= '0;
`endif
        end else if (accept) begin
            if (iter_start) begin
                state_q <= BUSY;
            end else begin
                state_q     <= DONE;
                result_q    <= res1_d;
                remainder_q <= rem1_d;
                err_q       <= err1_d;
`ifdef SEQ_ALU_FLAGS_EN
                flags_q     <= flags1_d;
`endif
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (it_done) begin
                        state_q     <= DONE;
                        result_q    <= it_prod;
                        remainder_q <= it_rem;
                        err_q       <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
                        flags_q     <= flagsi_d;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.err       = err_q;

endmodule
